// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : Shared types and encodings for the multicycle RV32I control FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // An instruction retires when one of its final states hands back to FETCH.
    function automatic logic retires(input statetype cur, input statetype nxt);
        return (nxt == FETCH) &&
               ((cur == MEMWB) || (cur == MEMWRITE) || (cur == ALUWB) || (cur == BEQ));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_perf_cnt.sv
// ============================================================================
// Module : mc_perf_cnt
// Brief  : Free-running cycle and retired-instruction counters, wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mc_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_retire,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (i_retire) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule

`default_nettype wire

// File: rtl/mc_main_fsm.sv
// ============================================================================
// Module : mc_main_fsm
// Brief  : Main control FSM of the multicycle RV32I core. Optional
//          performance counters are built when MC_PERF_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             adr_src,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    statetype r_state;
    statetype w_next_state;
    logic     w_pc_update;
    logic     w_branch;
    logic     w_ir_write;
    logic     w_reg_write;
    logic     w_mem_write;
    logic     w_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_illegal    = 1'b0;
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RD2;
        alu_op       = ALUOP_ADD;

        case (r_state)
            FETCH: begin
                result_src  = RES_ALURESULT;
                alu_src_b   = SRCB_FOUR;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
                if (mem_ready) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_R:         w_next_state = EXECR;
                    OP_I:         w_next_state = EXECI;
                    OP_JAL:       w_next_state = JAL;
                    OP_BEQ:       w_next_state = BEQ;
                    default:      w_next_state = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a    = SRCA_RD1;
                alu_src_b    = SRCB_IMM;
                w_next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    w_next_state = MEMWB;
                end
            end
            MEMWB: begin
                result_src   = RES_DATA;
                w_reg_write  = 1'b1;
                w_next_state = FETCH;
            end
            MEMWRITE: begin
                // The strobe stays up for the whole access, not just its last cycle.
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_next_state = FETCH;
                end
            end
            EXECR: begin
                alu_src_a    = SRCA_RD1;
                alu_src_b    = SRCB_RD2;
                alu_op       = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a    = SRCA_RD1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = ALUWB;
            end
            ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = FETCH;
            end
            BEQ: begin
                alu_src_a    = SRCA_RD1;
                alu_src_b    = SRCB_RD2;
                alu_op       = ALUOP_SUB;
                w_branch     = 1'b1;
                w_next_state = FETCH;
            end
            TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = TRAP;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // Reset masks the enables combinationally so nothing writes after the asserting edge.
    assign pc_write  = reset & (w_pc_update | (w_branch & zero));
    assign ir_write  = reset & w_ir_write;
    assign reg_write = reset & w_reg_write;
    assign mem_write = reset & w_mem_write;
    assign illegal   = reset & w_illegal;

`ifdef MC_PERF_CNT_EN
    logic w_retire;

    assign w_retire = retires(r_state, w_next_state);

    mc_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .i_retire     (w_retire),
        .o_cycle_cnt  (cycle_cnt),
        .o_instret_cnt(instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
// ============================================================================
// Module : tb_mc_main_fsm
// Brief  : Directed self-checking bench for mc_main_fsm (MC_PERF_CNT_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mc_main_fsm;

    localparam int CNT_W = 32;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    logic             s_pc_write, s_ir_write, s_reg_write, s_mem_write, s_adr_src, s_illegal;
    logic [1:0]       s_result_src, s_alu_src_a, s_alu_src_b, s_alu_op;
    logic [3:0]       s_cycle_cnt, s_instret_cnt;

    always #5 clk = ~clk;

    mc_main_fsm #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // Narrow instance so counter wrap-around is reached in a short run.
    mc_main_fsm #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .ir_write(s_ir_write), .reg_write(s_reg_write),
        .mem_write(s_mem_write), .adr_src(s_adr_src), .result_src(s_result_src),
        .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
        .illegal(s_illegal), .cycle_cnt(s_cycle_cnt), .instret_cnt(s_instret_cnt)
    );

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic       illegal;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        logic       mr;
        logic       retire;
        exp_t       e;
    } vec_t;

    vec_t        q[$];
    int          passed = 0;
    int          total  = 0;
    logic [63:0] model_cyc  = 0;
    logic [63:0] model_inst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic pcw, input logic irw, input logic rw, input logic mw,
                                input logic adr, input logic [1:0] res, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] aop, input logic ill);
        exp_t e;
        e = '{pc_write: pcw, ir_write: irw, reg_write: rw, mem_write: mw, adr_src: adr,
              result_src: res, a: a, b: b, aop: aop, illegal: ill};
        return e;
    endfunction

    function automatic exp_t dut_outs();
        return mk(pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                  alu_src_a, alu_src_b, alu_op, illegal);
    endfunction

    // Outputs expected while reset is held: no enables, FETCH mux settings.
    function automatic exp_t idle_fetch();
        return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    endfunction

    task automatic push(input logic [6:0] o, input logic z, input logic mr,
                        input logic ret, input exp_t e);
        vec_t v;
        v.op = o; v.zero = z; v.mr = mr; v.retire = ret; v.e = e;
        q.push_back(v);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its per-cycle stimulus and expected outputs.
    task automatic add_instr(input logic [6:0] o, input logic z, input int fwait,
                             input int mwait, input int trap_cyc,
                             output int n, output int n_mw, output int n_rw);
        int start;
        start = q.size();
        for (int i = 0; i < fwait; i++) push(o, z, 0, 0, idle_fetch());
        push(o, z, 1, 0, mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
        push(o, z, rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0));
        case (o)
            T_LW: begin
                push(o, z, rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
                for (int i = 0; i < mwait; i++)
                    push(o, z, 0, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                push(o, z, 1, 0, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                push(o, z, rnd(), 1, mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0));
            end
            T_SW: begin
                push(o, z, rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
                for (int i = 0; i < mwait; i++)
                    push(o, z, 0, 0, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
                push(o, z, 1, 1, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
            end
            T_R, T_I, T_JAL: begin
                if (o == T_R)
                    push(o, z, rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
                else if (o == T_I)
                    push(o, z, rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0));
                else
                    push(o, z, rnd(), 0, mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
                push(o, z, rnd(), 1, mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
            end
            T_BEQ: push(o, z, rnd(), 1, mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0));
            default: begin
                for (int i = 0; i < trap_cyc; i++)
                    push(o, rnd(), rnd(), 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1));
            end
        endcase
        n = q.size() - start;
        n_mw = 0;
        n_rw = 0;
        for (int i = start; i < q.size(); i++) begin
            n_mw += int'(q[i].e.mem_write);
            n_rw += int'(q[i].e.reg_write);
        end
    endtask

    // Entered and left at posedge+1; outputs compared on the falling edge.
    task automatic run_q(input int limit);
        int k;
        vec_t v;
        k = 0;
        while (q.size() > 0 && (limit < 0 || k < limit)) begin
            v = q.pop_front();
            op = v.op; zero = v.zero; mem_ready = v.mr;
            @(negedge clk);
            chk("outputs", 64'(dut_outs()), 64'(v.e));
`ifdef MC_PERF_CNT_EN
            chk("cycle_cnt", 64'(cycle_cnt), 64'(model_cyc[CNT_W-1:0]));
            chk("instret_cnt", 64'(instret_cnt), 64'(model_inst[CNT_W-1:0]));
            chk("cycle_cnt_w4", 64'(s_cycle_cnt), 64'(model_cyc[3:0]));
            chk("instret_cnt_w4", 64'(s_instret_cnt), 64'(model_inst[3:0]));
`else
            chk("cnt_tied_zero", 64'({cycle_cnt, instret_cnt}), 64'd0);
`endif
            @(posedge clk);
            if (reset) begin
                model_cyc++;
                if (v.retire) model_inst++;
            end
            #1;
            k++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ready = 1'b1; op = T_R; zero = 1'b1;
        model_cyc = 0; model_inst = 0;
        @(negedge clk);
        chk("in_reset", 64'(dut_outs()), 64'(idle_fetch()));
`ifdef MC_PERF_CNT_EN
        chk("cnt_in_reset", 64'({cycle_cnt, instret_cnt}), 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int n, nmw, nrw;
        reset = 1'b0; op = T_R; zero = 1'b0; mem_ready = 1'b1;
        #2;
        do_reset();

        add_instr(T_R, 0, 0, 0, 0, n, nmw, nrw);
        chk("len_rtype", 64'(n), 64'd4);
        chk("rw_rtype", 64'(nrw), 64'd1);
        run_q(-1);

        add_instr(T_LW, 0, 0, 2, 0, n, nmw, nrw);
        chk("len_lw_wait2", 64'(n), 64'd7);
        chk("rw_lw", 64'(nrw), 64'd1);
        run_q(-1);

        add_instr(T_SW, 0, 0, 3, 0, n, nmw, nrw);
        chk("len_sw_wait3", 64'(n), 64'd7);
        chk("mw_sw", 64'(nmw), 64'd4);
        chk("rw_sw", 64'(nrw), 64'd0);
        run_q(-1);

        add_instr(T_BEQ, 1, 0, 0, 0, n, nmw, nrw);
        chk("len_beq_taken", 64'(n), 64'd3);
        run_q(-1);
        add_instr(T_BEQ, 0, 0, 0, 0, n, nmw, nrw);
        chk("len_beq_not", 64'(n), 64'd3);
        run_q(-1);

        add_instr(T_LW, 0, 0, 0, 0, n, nmw, nrw);
        chk("len_lw", 64'(n), 64'd5);
        run_q(-1);
        add_instr(T_SW, 0, 0, 0, 0, n, nmw, nrw);
        chk("len_sw", 64'(n), 64'd4);
        run_q(-1);
        add_instr(T_I, 0, 2, 0, 0, n, nmw, nrw);
        chk("len_itype_fwait2", 64'(n), 64'd6);
        run_q(-1);
        add_instr(T_JAL, 0, 0, 0, 0, n, nmw, nrw);
        chk("len_jal", 64'(n), 64'd4);
        run_q(-1);

        // Two R-type and one beq straight out of reset.
        do_reset();
        add_instr(T_R, 0, 0, 0, 0, n, nmw, nrw);
        add_instr(T_R, 0, 0, 0, 0, n, nmw, nrw);
        add_instr(T_BEQ, 1, 0, 0, 0, n, nmw, nrw);
        run_q(-1);
`ifdef MC_PERF_CNT_EN
        chk("perf_cycle_11", 64'(cycle_cnt), 64'd11);
        chk("perf_instret_3", 64'(instret_cnt), 64'd3);
`endif

        // Reset in the middle of a store access.
        add_instr(T_SW, 0, 0, 2, 0, n, nmw, nrw);
        run_q(3);
        mem_ready = 1'b0;
        #1;
        chk("memwrite_before_rst", 64'(mem_write), 64'd1);
        reset = 1'b0;
        model_cyc = 0; model_inst = 0;
        #1;
        chk("mid_reset_outs", 64'(dut_outs()), 64'(idle_fetch()));
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        add_instr(T_R, 0, 0, 0, 0, n, nmw, nrw);
        run_q(-1);

        // Unsupported opcode parks the core until reset.
        add_instr(T_BAD, 0, 0, 0, 12, n, nmw, nrw);
        chk("len_trap", 64'(n), 64'd14);
        run_q(-1);
        do_reset();
        chk("illegal_cleared", 64'(illegal), 64'd0);
        add_instr(T_R, 0, 0, 0, 0, n, nmw, nrw);
        run_q(-1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
